traffic_sensor: RTL

TRAFFIC_SENSOR -- requirements
Module: traffic_sensor

---
 rtl/traffic_pkg.sv | 35 +++
 rtl/sensor_lane.sv | 164 ++++++++++++++++
 rtl/traffic_sensor.sv | 59 +++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic sensor and the traffic light controller.
// Optional feature macro: SENSOR_STUCK_DETECT_EN (adds the FAULT lane state).
package traffic_pkg;

  // Per-lane sensor state
`ifdef SENSOR_STUCK_DETECT_EN
  typedef enum logic [2:0] {
    LANE_IDLE  = 3'd0,
    LANE_QUAL  = 3'd1,
    LANE_OCC   = 3'd2,
    LANE_HOLD  = 3'd3,
    LANE_FAULT = 3'd4
  } lane_state_t;
`else
  typedef enum logic [2:0] {
    LANE_IDLE = 3'd0,
    LANE_QUAL = 3'd1,
    LANE_OCC  = 3'd2,
    LANE_HOLD = 3'd3
  } lane_state_t;
`endif

  // Light codes shared with trafficfsm
  localparam logic [1:0] GREEN  = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] RED    = 2'b10;

  // Largest of three elaboration-time values, for counter sizing
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sensor_lane.sv
// One loop-detector lane: 2-flop synchronizer, debounce/hold FSM,
// saturating vehicle counter. With SENSOR_STUCK_DETECT_EN the shared
// counter doubles as an occupancy timer that trips FAULT.
module sensor_lane
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 8
`ifdef SENSOR_STUCK_DETECT_EN
  ,
  parameter int STUCK_CYCLES    = 256
`endif
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       raw_i,
  output logic       t_o,
  output logic       fault_o,
  output logic [7:0] cnt_o
);

`ifdef SENSOR_STUCK_DETECT_EN
  localparam int CNT_MAX = max3(DEBOUNCE_CYCLES, HOLD_CYCLES, STUCK_CYCLES);
`else
  localparam int CNT_MAX = max3(DEBOUNCE_CYCLES, HOLD_CYCLES, 1);
`endif
  localparam int CW = $clog2(CNT_MAX + 1);

  // Counter values on which the last qualifying sample completes a run
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
`ifdef SENSOR_STUCK_DETECT_EN
  localparam logic [CW-1:0] STUCK_LAST = CW'(STUCK_CYCLES - 1);
`endif

  logic [1:0]    sync_q;
  logic          s;
  lane_state_t   state_q;
  logic [CW-1:0] tmr_q;
  logic          t_q;
  logic [7:0]    vcnt_q;
  logic [7:0]    vcnt_inc;

  assign s        = sync_q[1];
  assign vcnt_inc = (vcnt_q == 8'hFF) ? vcnt_q : vcnt_q + 8'd1;

  // Two-flop synchronizer for the asynchronous loop input
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= 2'b00;
    else       sync_q <= {sync_q[0], raw_i};
  end

`ifdef SENSOR_STUCK_DETECT_EN
  logic fault_q;
  assign fault_o = fault_q;
`else
  assign fault_o = 1'b0;
`endif

  // Lane FSM with registered T, fault and vehicle count
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= LANE_IDLE;
      tmr_q   <= '0;
      t_q     <= 1'b0;
      vcnt_q  <= '0;
`ifdef SENSOR_STUCK_DETECT_EN
      fault_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        LANE_IDLE: begin
          if (s) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state_q <= LANE_OCC;
              tmr_q   <= '0;
              t_q     <= 1'b1;
              vcnt_q  <= vcnt_inc;
            end else begin
              state_q <= LANE_QUAL;
              tmr_q   <= CW'(1);
            end
          end
        end
        LANE_QUAL: begin
          if (!s) begin
            // glitch: drop it without counting
            state_q <= LANE_IDLE;
            tmr_q   <= '0;
          end else if (tmr_q == DEB_LAST) begin
            state_q <= LANE_OCC;
            tmr_q   <= '0;
            t_q     <= 1'b1;
            vcnt_q  <= vcnt_inc;
          end else begin
            tmr_q <= tmr_q + CW'(1);
          end
        end
        LANE_OCC: begin
`ifdef SENSOR_STUCK_DETECT_EN
          if (tmr_q == STUCK_LAST) begin
            // occupied too long: treat the loop as stuck
            state_q <= LANE_FAULT;
            tmr_q   <= '0;
            t_q     <= 1'b0;
            fault_q <= 1'b1;
          end else
`endif
          if (!s) begin
            if (HOLD_CYCLES == 1) begin
              state_q <= LANE_IDLE;
              tmr_q   <= '0;
              t_q     <= 1'b0;
            end else begin
              state_q <= LANE_HOLD;
              tmr_q   <= CW'(1);
            end
          end else begin
`ifdef SENSOR_STUCK_DETECT_EN
            tmr_q <= tmr_q + CW'(1);
`else
            tmr_q <= '0;
`endif
          end
        end
        LANE_HOLD: begin
          if (s) begin
            // vehicle still there: resume without re-debounce or count
            state_q <= LANE_OCC;
            tmr_q   <= '0;
          end else if (tmr_q == HOLD_LAST) begin
            state_q <= LANE_IDLE;
            tmr_q   <= '0;
            t_q     <= 1'b0;
          end else begin
            tmr_q <= tmr_q + CW'(1);
          end
        end
`ifdef SENSOR_STUCK_DETECT_EN
        LANE_FAULT: begin
          if (s) begin
            tmr_q <= '0;
          end else if (tmr_q == HOLD_LAST) begin
            state_q <= LANE_IDLE;
            tmr_q   <= '0;
            fault_q <= 1'b0;
          end else begin
            tmr_q <= tmr_q + CW'(1);
          end
        end
`endif
        default: begin
          state_q <= LANE_IDLE;
          tmr_q   <= '0;
          t_q     <= 1'b0;
        end
      endcase
    end
  end

  assign t_o   = t_q;
  assign cnt_o = vcnt_q;

endmodule

// File: rtl/traffic_sensor.sv
// Two-lane loop sensor front end for the traffic light controller.
// Optional feature macro: SENSOR_STUCK_DETECT_EN (stuck-loop fault detect).
module traffic_sensor #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 8,
  parameter int STUCK_CYCLES    = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       loop_a_raw,
  input  logic       loop_b_raw,
  output logic       Ta,
  output logic       Tb,
  output logic       fault_a,
  output logic       fault_b,
  output logic [7:0] cnt_a,
  output logic [7:0] cnt_b
);

  // Reject out-of-range configurations at elaboration
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255 ||
      HOLD_CYCLES < 1 || HOLD_CYCLES > 255 ||
      STUCK_CYCLES < 2 || STUCK_CYCLES > 65535) begin : g_param_check
    $error("traffic_sensor: parameter out of legal range");
  end

  sensor_lane #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .HOLD_CYCLES     (HOLD_CYCLES)
`ifdef SENSOR_STUCK_DETECT_EN
    ,
    .STUCK_CYCLES    (STUCK_CYCLES)
`endif
  ) u_lane_a (
    .clk_i   (clk),
    .rst_i   (reset),
    .raw_i   (loop_a_raw),
    .t_o     (Ta),
    .fault_o (fault_a),
    .cnt_o   (cnt_a)
  );

  sensor_lane #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .HOLD_CYCLES     (HOLD_CYCLES)
`ifdef SENSOR_STUCK_DETECT_EN
    ,
    .STUCK_CYCLES    (STUCK_CYCLES)
`endif
  ) u_lane_b (
    .clk_i   (clk),
    .rst_i   (reset),
    .raw_i   (loop_b_raw),
    .t_o     (Tb),
    .fault_o (fault_b),
    .cnt_o   (cnt_b)
  );

endmodule
